// File: rtl/iscas_bist_harness.sv
// BIST harness: an LFSR drives the benchmark core's primary inputs, and a MISR compacts
// the core's primary outputs. The final signature is compared against a golden value.
module iscas_bist_harness #(
  parameter int unsigned IN_WIDTH     = 35,
  parameter int unsigned OUT_WIDTH    = 24,
  parameter int unsigned PATTERNS     = 1024,
  parameter int unsigned FLUSH_CYCLES = 16,
  parameter logic [63:0] SEED         = 64'h1,
  parameter logic [31:0] GOLDEN       = 32'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [31:0]          signature,
  output logic [IN_WIDTH-1:0]  dut_in,
  input  logic [OUT_WIDTH-1:0] dut_out
);

  // A zero seed would lock the LFSR in the all-zero state.
  localparam logic [63:0] SeedEff = (SEED == 64'h0) ? 64'h1 : SEED;
  localparam int unsigned MaxCnt = (PATTERNS > FLUSH_CYCLES) ? PATTERNS : FLUSH_CYCLES;
  localparam int unsigned CntW = $clog2(MaxCnt + 1);
  localparam logic [CntW-1:0] FlushLast = CntW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);
  localparam logic [CntW-1:0] RunLast = CntW'(PATTERNS - 1);

  typedef enum logic [1:0] {StIdle, StFlush, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [63:0]     lfsr_q, lfsr_next;
  logic [31:0]     misr_q, misr_next;
  logic [CntW-1:0] cnt_q;
  logic            pass_q;
  logic            launch;

  assign launch    = start && ((state_q == StIdle) || (state_q == StDone));
  assign lfsr_next = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
  assign misr_next = {misr_q[30:0], misr_q[31] ^ misr_q[21] ^ misr_q[1] ^ misr_q[0]}
                     ^ 32'(dut_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (start) state_d = (FLUSH_CYCLES == 0) ? StRun : StFlush;
      StFlush:        if (cnt_q == FlushLast) state_d = StRun;
      StRun:          if (cnt_q == RunLast) state_d = StDone;
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    busy = (state_q == StFlush) || (state_q == StRun);
    done = (state_q == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SeedEff;
      misr_q <= '0;
      cnt_q  <= '0;
      pass_q <= 1'b0;
    end else if (launch) begin
      lfsr_q <= SeedEff;
      misr_q <= '0;
      cnt_q  <= '0;
      pass_q <= 1'b0;
    end else begin
      case (state_q)
        StFlush: begin
          lfsr_q <= lfsr_next;
          cnt_q  <= (cnt_q == FlushLast) ? '0 : cnt_q + CntW'(1);
        end
        StRun: begin
          lfsr_q <= lfsr_next;
          misr_q <= misr_next;
          // The counter parks on its terminal value; the next launch clears it.
          if (cnt_q == RunLast) pass_q <= (misr_next == GOLDEN);
          else                  cnt_q  <= cnt_q + CntW'(1);
        end
        default: ;
      endcase
    end
  end

  assign pass      = pass_q;
  assign signature = misr_q;
  assign dut_in    = lfsr_q[IN_WIDTH-1:0];

endmodule

// File: tb/tb_iscas_bist_harness.sv
// Scoreboarded random bench: five harness instances in loopback, each with its own
// flush/pattern/seed/golden setting, checked against a stimulus-list reference model.
module tb_iscas_bist_harness;

  localparam int N = 5;
  localparam logic [N-1:0][31:0] FT = {32'd16, 32'd3, 32'd3, 32'd0, 32'd0};
  localparam logic [N-1:0][31:0] PT = {32'd1024, 32'd1, 32'd1, 32'd2, 32'd1};
  localparam logic [N-1:0][63:0] ST = {64'h0, 64'h1, 64'h1, 64'h1, 64'h1};
  localparam logic [N-1:0][31:0] GT = {32'h0, 32'h9, 32'h8, 32'h1, 32'h1};

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  start, busy, done, pass;
  logic [31:0]   sig [N];
  logic [34:0]   din [N];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [31:0] sig;
    logic        pass;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    iscas_bist_harness #(
      .IN_WIDTH(35), .OUT_WIDTH(24), .PATTERNS(PT[g]), .FLUSH_CYCLES(FT[g]),
      .SEED(ST[g]), .GOLDEN(GT[g])
    ) u_dut (
      .clk(clk), .rst(rst), .start(start[g]), .busy(busy[g]), .done(done[g]),
      .pass(pass[g]), .signature(sig[g]), .dut_in(din[g]), .dut_out(din[g][23:0])
    );
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: list the words applied during the RUN phase, then fold them into a MISR.
  function automatic logic [31:0] model_sig(input int unsigned f, input int unsigned p,
                                            input logic [63:0] seed);
    logic [63:0] s;
    logic [31:0] m;
    logic [23:0] words[$];
    s = (seed == 64'h0) ? 64'h1 : seed;
    m = '0;
    for (int unsigned i = 0; i < f + p; i++) begin
      if (i >= f) words.push_back(s[23:0]);
      s = {s[62:0], s[63] ^ s[62] ^ s[60] ^ s[59]};
    end
    foreach (words[i]) m = {m[30:0], m[31] ^ m[21] ^ m[1] ^ m[0]} ^ {8'h0, words[i]};
    return m;
  endfunction

  // Monitor: pops an expectation on every rising done and checks busy duration.
  int   busy_cnt [N];
  logic done_prev [N];
  logic busy_prev [N];
  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (rst) begin
        busy_cnt[g] = 0;
      end else begin
        if (busy[g] && !busy_prev[g]) check($sformatf("pass_clear[%0d]", g), pass[g], 0);
        if (busy[g]) begin
          busy_cnt[g]++;
          if (done[g]) check($sformatf("done_while_busy[%0d]", g), done[g], 0);
        end
        if (done[g] && !done_prev[g]) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done[%0d]: got done with no pending run", g);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("done_id[%0d]", g), g, e.id);
            check($sformatf("signature[%0d]", g), sig[g], e.sig);
            check($sformatf("pass[%0d]", g), pass[g], e.pass);
            check($sformatf("busy_cycles[%0d]", g), busy_cnt[g], FT[g] + PT[g]);
          end
          busy_cnt[g] = 0;
        end
      end
      done_prev[g] = done[g];
      busy_prev[g] = busy[g];
    end
  end

  task automatic push_exp(input int g);
    exp_t e;
    e.id   = g;
    e.sig  = model_sig(FT[g], PT[g], ST[g]);
    e.pass = (e.sig == GT[g]);
    exp_q.push_back(e);
  endtask

  task automatic pulse_start(input int g);
    @(posedge clk);
    #1 start[g] = 1'b1;
    @(posedge clk);
    #1 start[g] = 1'b0;
  endtask

  // One complete run; mid >= 0 also pulses start again at that RUN cycle.
  task automatic run(input int g, input int mid);
    bit seen;
    repeat ($urandom_range(0, 4)) @(posedge clk);
    push_exp(g);
    pulse_start(g);
    if (mid >= 0) begin
      repeat (FT[g] + mid - 1) @(posedge clk);
      #1 start[g] = 1'b1;
      @(posedge clk);
      #1 start[g] = 1'b0;
    end
    seen = 1'b0;
    for (int i = 0; i < int'(FT[g] + PT[g]) + 8 && !seen; i++) begin
      @(negedge clk);
      seen = done[g];
    end
    check($sformatf("done_timeout[%0d]", g), seen, 1);
    @(negedge clk);
    check($sformatf("done_held[%0d]", g), done[g], 1);
  endtask

  task automatic check_reset_state(input string tag);
    for (int g = 0; g < N; g++) begin
      check($sformatf("%s_busy[%0d]", tag, g), busy[g], 0);
      check($sformatf("%s_done[%0d]", tag, g), done[g], 0);
      check($sformatf("%s_pass[%0d]", tag, g), pass[g], 0);
      check($sformatf("%s_sig[%0d]", tag, g), sig[g], 0);
      check($sformatf("%s_din[%0d]", tag, g), din[g], 35'h1);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // Every short setup twice (rerun determinism), then a random mix.
    for (int r = 0; r < 2; r++)
      for (int g = 0; g < 4; g++) run(g, -1);
    for (int k = 0; k < 8; k++) run($urandom_range(0, 3), -1);

    // Start while busy must be ignored.
    run(4, 10);

    // Reset partway through RUN discards the run.
    push_exp(4);
    pulse_start(4);
    repeat (FT[4] + 5 - 1) @(posedge clk);
    #1 rst = 1'b1;
    void'(exp_q.pop_back());
    @(negedge clk);
    check_reset_state("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    for (int g = 0; g < 3; g++) run(g, -1);

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
